// File: rtl/apb_requester_arb.sv
// Two-client APB requester: round-robin grant, IDLE/SETUP/ACCESS sequencing,
// PREADY wait states and a wait-state timeout that reports an error.
module apb_requester_arb #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int TIMEOUT    = 16,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  req0,
  input  logic                  wr0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] wdata0,
  output logic                  ack0,
  output logic                  done0,
  output logic                  err0,
  output logic [DATA_WIDTH-1:0] rdata0,
  input  logic                  req1,
  input  logic                  wr1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  ack1,
  output logic                  done1,
  output logic                  err1,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  busy,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  localparam logic [CNT_WIDTH-1:0] TO_LAST = CNT_WIDTH'(TIMEOUT - 1);

  state_t                state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  last_q, last_d;
  logic                  gnt_q, gnt_d;
  logic                  wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  psel_q, psel_d;
  logic                  pen_q, pen_d;
  logic                  ack0_q, ack0_d, ack1_q, ack1_d;
  logic                  done0_q, done0_d, done1_q, done1_d;
  logic                  err0_q, err0_d, err1_q, err1_d;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic                  pick1;
  logic                  fin;
  logic                  to_hit;
  logic [DATA_WIDTH-1:0] rd;

  // Both requesting: the one not granted last time wins.
  assign pick1 = req1 && (!req0 || !last_q);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    gnt_d    = gnt_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    psel_d   = 1'b0;
    pen_d    = 1'b0;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    done0_d  = 1'b0;
    done1_d  = 1'b0;
    err0_d   = 1'b0;
    err1_d   = 1'b0;
    rdata0_d = '0;
    rdata1_d = '0;
    fin      = 1'b0;
    to_hit   = 1'b0;
    rd       = '0;
    unique case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          gnt_d   = pick1;
          last_d  = pick1;
          wr_d    = pick1 ? wr1 : wr0;
          addr_d  = pick1 ? addr1 : addr0;
          wdata_d = '0;
          if (pick1 ? wr1 : wr0)
            wdata_d = pick1 ? wdata1 : wdata0;
          ack0_d  = !pick1;
          ack1_d  = pick1;
          psel_d  = 1'b1;
          state_d = SETUP;
        end
      end
      SETUP: begin
        cnt_d   = '0;
        psel_d  = 1'b1;
        pen_d   = 1'b1;
        state_d = ACCESS;
      end
      ACCESS: begin
        psel_d = 1'b1;
        pen_d  = 1'b1;
        if (PREADY) begin
          fin = 1'b1;
          rd  = wr_q ? '0 : PRDATA;
        end else if (TIMEOUT != 0 && cnt_q == TO_LAST) begin
          fin    = 1'b1;
          to_hit = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
        if (fin) begin
          psel_d   = 1'b0;
          pen_d    = 1'b0;
          state_d  = IDLE;
          done0_d  = !gnt_q;
          done1_d  = gnt_q;
          err0_d   = to_hit && !gnt_q;
          err1_d   = to_hit && gnt_q;
          rdata0_d = gnt_q ? '0 : rd;
          rdata1_d = gnt_q ? rd : '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      last_q   <= 1'b1;
      gnt_q    <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      psel_q   <= 1'b0;
      pen_q    <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      err0_q   <= 1'b0;
      err1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      gnt_q    <= gnt_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      psel_q   <= psel_d;
      pen_q    <= pen_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
      err0_q   <= err0_d;
      err1_q   <= err1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  assign ack0    = ack0_q;
  assign ack1    = ack1_q;
  assign done0   = done0_q;
  assign done1   = done1_q;
  assign err0    = err0_q;
  assign err1    = err1_q;
  assign rdata0  = rdata0_q;
  assign rdata1  = rdata1_q;
  assign busy    = psel_q;
  assign PSEL    = psel_q;
  assign PENABLE = pen_q;
  assign PWRITE  = wr_q;
  assign PADDR   = addr_q;
  assign PWDATA  = wdata_q;

endmodule

// File: tb/tb_apb_requester_arb.sv
// Directed bench for apb_requester_arb: vector table plus arbitration,
// reset and back-to-back sequences.
module tb_apb_requester_arb;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic        req0, wr0, req1, wr1;
  logic [15:0] addr0, wdata0, addr1, wdata1;
  logic        ack0, done0, err0, ack1, done1, err1;
  logic [15:0] rdata0, rdata1;
  logic        busy, PSEL, PENABLE, PWRITE, PREADY;
  logic [15:0] PADDR, PWDATA, PRDATA;

  int n_cmp = 0;
  int n_bad = 0;

  apb_requester_arb #(
    .ADDR_WIDTH(16), .DATA_WIDTH(16), .TIMEOUT(16), .CNT_WIDTH(8)
  ) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .req0(req0), .wr0(wr0), .addr0(addr0), .wdata0(wdata0),
    .ack0(ack0), .done0(done0), .err0(err0), .rdata0(rdata0),
    .req1(req1), .wr1(wr1), .addr1(addr1), .wdata1(wdata1),
    .ack1(ack1), .done1(done1), .err1(err1), .rdata1(rdata1),
    .busy(busy), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    bit          id;
    bit          wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          waits;
    logic [15:0] prdata;
    logic [15:0] exp_pw;
    logic [15:0] exp_rd;
    bit          exp_err;
    int          exp_lat;
    int          exp_en;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input int k, input vec_t v);
    int cyc, acc, busbad, other;
    bit fin;
    cyc = 0; acc = 0; busbad = 0; other = 0; fin = 0;
    @(negedge PCLK);
    PREADY = 0;
    PRDATA = v.prdata;
    if (v.id) begin
      req1 = 1; wr1 = v.wr; addr1 = v.addr; wdata1 = v.wdata;
    end else begin
      req0 = 1; wr0 = v.wr; addr0 = v.addr; wdata0 = v.wdata;
    end
    while (!fin && cyc < 60) begin
      @(negedge PCLK);
      cyc++;
      if (v.id ? ack1 : ack0) begin
        req0 = 0; req1 = 0;
      end
      if (v.id ? (ack0 | done0) : (ack1 | done1)) other++;
      if (PSEL && (PADDR !== v.addr || PWRITE !== v.wr ||
                   PWDATA !== v.exp_pw)) busbad++;
      if (PENABLE) acc++;
      if (v.id ? done1 : done0) begin
        fin = 1;
        chk($sformatf("v%0d_rdata", k), v.id ? rdata1 : rdata0, v.exp_rd);
        chk($sformatf("v%0d_err", k), v.id ? err1 : err0, v.exp_err);
        chk($sformatf("v%0d_lat", k), cyc, v.exp_lat);
        chk($sformatf("v%0d_penable", k), acc, v.exp_en);
      end
      PREADY = PENABLE && (acc == v.waits + 1);
    end
    chk($sformatf("v%0d_done_seen", k), fin, 1);
    chk($sformatf("v%0d_bus", k), busbad, 0);
    chk($sformatf("v%0d_other", k), other, 0);
    @(negedge PCLK);
    chk($sformatf("v%0d_clear", k),
        {done0, done1, err0, err1, rdata0, rdata1}, 0);
  endtask

  vec_t vt[7];

  initial begin
    int order[$];
    int c, nd, nlow, tdone;
    bit seen;

    vt[0] = '{0, 1, 16'h0004, 16'hA5A5, 0, 16'hFFFF, 16'hA5A5,
              16'h0000, 0, 3, 1};
    vt[1] = '{1, 0, 16'h0010, 16'h0000, 2, 16'h1234, 16'h0000,
              16'h1234, 0, 5, 3};
    vt[2] = '{0, 0, 16'h0020, 16'hBEEF, 0, 16'h00C3, 16'h0000,
              16'h00C3, 0, 3, 1};
    vt[3] = '{1, 1, 16'h0030, 16'h5A5A, 1, 16'h7777, 16'h5A5A,
              16'h0000, 0, 4, 2};
    vt[4] = '{0, 0, 16'h0040, 16'h0000, 20, 16'hABCD, 16'h0000,
              16'h0000, 1, 18, 16};
    vt[5] = '{0, 0, 16'h0044, 16'h0000, 15, 16'h4321, 16'h0000,
              16'h4321, 0, 18, 16};
    vt[6] = '{1, 1, 16'h0048, 16'h9999, 20, 16'h1111, 16'h9999,
              16'h0000, 1, 18, 16};

    PRESET = 1;
    req0 = 0; wr0 = 0; addr0 = 0; wdata0 = 0;
    req1 = 0; wr1 = 0; addr1 = 0; wdata1 = 0;
    PREADY = 0; PRDATA = 0;
    repeat (2) @(negedge PCLK);
    chk("reset_outs",
        {ack0, done0, err0, rdata0, ack1, done1, err1, rdata1,
         busy, PSEL, PENABLE, PWRITE, PADDR, PWDATA}, 0);

    // Contention from reset: grants alternate starting with requester 0.
    @(negedge PCLK);
    PRESET = 0;
    req0 = 1; wr0 = 1; addr0 = 16'h0100; wdata0 = 16'h0A0A;
    req1 = 1; wr1 = 1; addr1 = 16'h0200; wdata1 = 16'h0B0B;
    PREADY = 1;
    c = 0; nd = 0; nlow = 0; tdone = 0;
    while (nd < 4 && c < 40) begin
      @(negedge PCLK);
      c++;
      if (ack0) order.push_back(0);
      if (ack1) order.push_back(1);
      if (!PSEL) nlow++;
      if (done0 || done1) nd++;
      if (nd == 4) begin
        tdone = c;
        req0 = 0; req1 = 0;
      end
    end
    chk("cont_nacks", order.size(), 4);
    if (order.size() == 4) begin
      chk("cont_g0", order[0], 0);
      chk("cont_g1", order[1], 1);
      chk("cont_g2", order[2], 0);
      chk("cont_g3", order[3], 1);
    end
    chk("cont_cycles", tdone, 12);
    chk("cont_psel_gaps", nlow, 4);
    PREADY = 0;
    repeat (2) @(negedge PCLK);

    foreach (vt[i]) run_vec(i, vt[i]);

    // Reset in the middle of a wait state.
    @(negedge PCLK);
    req0 = 1; wr0 = 0; addr0 = 16'h0070; PREADY = 0;
    repeat (4) @(negedge PCLK);
    req0 = 0;
    chk("rst_pre_acc", PENABLE, 1);
    #2 PRESET = 1;
    #1 chk("rst_async", {PSEL, PENABLE, busy}, 0);
    seen = 0;
    repeat (3) begin
      @(negedge PCLK);
      if (done0 | done1) seen = 1;
    end
    chk("rst_no_done", seen, 0);
    PRESET = 0;
    req0 = 1; req1 = 1; PREADY = 1;
    @(negedge PCLK);
    chk("rst_first_grant", {ack0, ack1}, 2'b10);
    @(negedge PCLK);
    @(negedge PCLK);
    chk("rst_done0", {done0, done1}, 2'b10);
    req0 = 0; req1 = 0;
    repeat (2) @(negedge PCLK);

    // Back-to-back on requester 0 with a new address.
    req0 = 1; wr0 = 1; addr0 = 16'h0060; wdata0 = 16'h1111;
    c = 0;
    while (!done0 && c < 20) begin
      @(negedge PCLK);
      c++;
    end
    chk("b2b_first_done", done0, 1);
    addr0 = 16'h0064; wdata0 = 16'h2222;
    @(negedge PCLK);
    chk("b2b_ack", ack0, 1);
    chk("b2b_paddr", PADDR, 16'h0064);
    chk("b2b_pwdata", PWDATA, 16'h2222);
    req0 = 0;
    c = 0;
    while (!done0 && c < 20) begin
      @(negedge PCLK);
      c++;
    end
    chk("b2b_second_done", done0, 1);
    chk("b2b_lat", c, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
